// File: rtl/dcache_miss_engine_pkg.sv
// Shared data-cache types: address fields, cache entry, RAM handshake and miss-engine states.
package dcache_miss_engine_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned CACHE_WORDS = 2;
  localparam int unsigned CACHE_TAG_W = 26;
  localparam int unsigned CACHE_IDX_W = 3;
  localparam int unsigned CACHE_BLK_W = 1;
  localparam int unsigned CACHE_BYT_W = 2;
  localparam int unsigned WORD_COUNT  = CACHE_BLK_W;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef struct packed {
    logic [CACHE_TAG_W-1:0] tag;
    logic [CACHE_IDX_W-1:0] idx;
    logic [CACHE_BLK_W-1:0] blkoff;
    logic [CACHE_BYT_W-1:0] bytoff;
  } dcachef_t;

  typedef struct packed {
    logic                     v;
    logic                     dirty;
    logic [CACHE_TAG_W-1:0]   tag;
    word_t [CACHE_WORDS-1:0]  data;
  } dcache_entry;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } miss_state_t;

endpackage

// File: rtl/dcache_miss_engine.sv
// Miss handler: writes back a dirty victim, then fetches the missing block word by word
// over the single-word RAM port and hands a clean entry back to the cache controller.
module dcache_miss_engine
  import dcache_miss_engine_pkg::*;
#(
  parameter int unsigned WORDS  = CACHE_WORDS,
  parameter int unsigned DTAG_W = CACHE_TAG_W,
  parameter int unsigned DIDX_W = CACHE_IDX_W,
  parameter int unsigned DBLK_W = WORD_COUNT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        miss_req,
  input  dcachef_t    miss_addr,
  input  dcache_entry victim,
  output logic        busy,
  output logic        fill_valid,
  output dcache_entry fill_entry,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output word_t       ram_store,
  input  word_t       ram_load,
  input  ramstate_t   ram_state
);

  miss_state_t         state, state_next;
  logic [DBLK_W-1:0]   wcnt, wcnt_next;
  logic [DTAG_W-1:0]   req_tag;
  logic [DIDX_W-1:0]   req_idx;
  logic [DTAG_W-1:0]   vic_tag;
  word_t [WORDS-1:0]   vic_data;
  word_t [WORDS-1:0]   line_buf;
  word_t [WORDS-1:0]   fill_data;
  logic                accept;
  logic                last_word;
  logic                ram_done;

  // Byte and block offsets of the miss address play no part in block-granular transfers.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{miss_addr.blkoff, miss_addr.bytoff};

  assign last_word = (wcnt == DBLK_W'(WORDS - 1));
  assign ram_done  = (ram_state == ACCESS);

  // State, word counter and latched request/victim/fetched data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      wcnt       <= '0;
      req_tag    <= '0;
      req_idx    <= '0;
      vic_tag    <= '0;
      vic_data   <= '0;
      line_buf   <= '0;
      fill_entry <= '0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
      if (accept) begin
        req_tag  <= miss_addr.tag;
        req_idx  <= miss_addr.idx;
        vic_tag  <= victim.tag;
        vic_data <= victim.data;
      end
      if (state == FILL && ram_done) begin
        line_buf[wcnt] <= ram_load;
        if (last_word) begin
          fill_entry.v     <= 1'b1;
          fill_entry.dirty <= 1'b0;
          fill_entry.tag   <= req_tag;
          fill_entry.data  <= fill_data;
        end
      end
    end
  end

  // Next-state and RAM/handshake decode from the registered state only.
  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    accept     = 1'b0;
    busy       = 1'b0;
    fill_valid = 1'b0;
    ram_ren    = 1'b0;
    ram_wen    = 1'b0;
    ram_addr   = '0;
    ram_store  = '0;
    fill_data  = line_buf;

    case (state)
      IDLE: begin
        if (miss_req) begin
          accept     = 1'b1;
          wcnt_next  = '0;
          state_next = (victim.v && victim.dirty) ? WB : FILL;
        end
      end
      WB: begin
        busy      = 1'b1;
        ram_wen   = 1'b1;
        ram_addr  = 32'({vic_tag, req_idx, wcnt, 2'b00});
        ram_store = vic_data[wcnt];
        if (ram_done) begin
          if (last_word) begin
            wcnt_next  = '0;
            state_next = FILL;
          end else begin
            wcnt_next = wcnt + DBLK_W'(1);
          end
        end
      end
      FILL: begin
        busy            = 1'b1;
        ram_ren         = 1'b1;
        ram_addr        = 32'({req_tag, req_idx, wcnt, 2'b00});
        fill_data[wcnt] = ram_load;
        if (ram_done) begin
          if (last_word) begin
            state_next = DONE;
          end else begin
            wcnt_next = wcnt + DBLK_W'(1);
          end
        end
      end
      DONE: begin
        busy       = 1'b1;
        fill_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_miss_engine.sv
// Directed bench for dcache_miss_engine: a scripted RAM responder plus hand-computed
// addresses, data and latencies for each miss scenario.
module tb_dcache_miss_engine;
  import dcache_miss_engine_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_req = 1'b0;
  dcachef_t    miss_addr = '0;
  dcache_entry victim = '0;
  logic        busy, fill_valid, ram_ren, ram_wen;
  dcache_entry fill_entry;
  logic [31:0] ram_addr;
  word_t       ram_store;
  word_t       ram_load = '0;
  ramstate_t   ram_state = FREE;

  int errors = 0;
  int checks = 0;

  dcache_miss_engine dut (
    .CLK        (clk),
    .RST        (rst),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .victim     (victim),
    .busy       (busy),
    .fill_valid (fill_valid),
    .fill_entry (fill_entry),
    .ram_ren    (ram_ren),
    .ram_wen    (ram_wen),
    .ram_addr   (ram_addr),
    .ram_store  (ram_store),
    .ram_load   (ram_load),
    .ram_state  (ram_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic dcache_entry mk(input logic v, input logic d, input logic [25:0] tag,
                                     input word_t w0, input word_t w1);
    dcache_entry e;
    e.v       = v;
    e.dirty   = d;
    e.tag     = tag;
    e.data[0] = w0;
    e.data[1] = w1;
    return e;
  endfunction

  // RAM responder: BUSY for lat_cfg cycles then ACCESS per word, optional one-shot ERROR.
  int          lat_cfg = 0;
  int          wait_cnt = 0;
  int          fv_count = 0;
  logic        err_arm = 1'b0;
  logic [31:0] err_addr = '0;
  logic        err_hold = 1'b0;
  logic [31:0] err_saved = '0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        prev_ren = 1'b0;
  word_t       rd_data [2];
  logic [31:0] rd_addr_q[$];
  logic [31:0] wr_addr_q[$];
  word_t       wr_data_q[$];

  always @(negedge clk) begin
    if (fill_valid) fv_count++;
    if (ram_ren || ram_wen) check("ren_wen_excl", 128'(ram_ren & ram_wen), 128'(0));
    if (err_hold) begin
      check("err_retry_addr", 128'(ram_addr), 128'(err_saved));
      err_hold = 1'b0;
    end
    if (prev_wait && (ram_ren || ram_wen)) begin
      check("wait_addr_hold", 128'(ram_addr), 128'(prev_addr));
      check("wait_ren_hold", 128'(ram_ren), 128'(prev_ren));
    end
    prev_wait = 1'b0;
    if (!(ram_ren || ram_wen)) begin
      ram_state = FREE;
      wait_cnt  = 0;
      ram_load  = '0;
    end else if (wait_cnt < lat_cfg) begin
      ram_state = BUSY;
      wait_cnt++;
      prev_wait = 1'b1;
      prev_addr = ram_addr;
      prev_ren  = ram_ren;
      ram_load  = 32'hBBBB_BBBB;
    end else if (err_arm && ram_ren && ram_addr == err_addr) begin
      ram_state = ERROR;
      err_arm   = 1'b0;
      err_hold  = 1'b1;
      err_saved = ram_addr;
      ram_load  = 32'hEEEE_EEEE;
    end else begin
      ram_state = ACCESS;
      wait_cnt  = 0;
      ram_load  = rd_data[ram_addr[2]];
      if (ram_wen) begin
        wr_addr_q.push_back(ram_addr);
        wr_data_q.push_back(ram_store);
      end else begin
        rd_addr_q.push_back(ram_addr);
      end
    end
  end

  task automatic clear_logs();
    rd_addr_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_pair(input string tag, input logic [31:0] q[$],
                            input logic [31:0] e0, input logic [31:0] e1);
    check({tag, "_count"}, 128'(q.size()), 128'(2));
    if (q.size() == 2) begin
      check({tag, "_0"}, 128'(q[0]), 128'(e0));
      check({tag, "_1"}, 128'(q[1]), 128'(e1));
    end
  endtask

  // Issue one miss, optionally pulse miss_req again at cycle pulse_at, wait for fill_valid.
  task automatic run_miss(input string tag, input logic [31:0] addr, input dcache_entry vic,
                          input int exp_lat, input int pulse_at);
    int lat;
    miss_addr = dcachef_t'(addr);
    victim    = vic;
    miss_req  = 1'b1;
    @(posedge clk); #1;
    miss_req = 1'b0;
    lat = 1;
    check({tag, "_busy_rise"}, 128'(busy), 128'(1));
    while (!fill_valid && lat < 60) begin
      if (lat == pulse_at) miss_req = 1'b1;
      @(posedge clk); #1;
      miss_req = 1'b0;
      lat++;
    end
    check({tag, "_fill_seen"}, 128'(fill_valid), 128'(1));
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
  endtask

  initial begin
    dcache_entry e;
    int fv_before;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_fill_valid", 128'(fill_valid), 128'(0));
    check("rst_ren", 128'(ram_ren), 128'(0));
    check("rst_wen", 128'(ram_wen), 128'(0));
    check("rst_addr", 128'(ram_addr), 128'(0));
    check("rst_store", 128'(ram_store), 128'(0));
    check("rst_entry", 128'(fill_entry), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean miss: tag 0x69, idx 1
    clear_logs();
    rd_data[0] = 32'hAAAA_0001;
    rd_data[1] = 32'hAAAA_0002;
    run_miss("clean", 32'h0000_1A48, mk(1'b1, 1'b0, 26'h7, 32'h1, 32'h2), 3, -1);
    e = mk(1'b1, 1'b0, 26'h69, 32'hAAAA_0001, 32'hAAAA_0002);
    check("clean_entry", 128'(fill_entry), 128'(e));
    check_pair("clean_rd", rd_addr_q, 32'h1A48, 32'h1A4C);
    check("clean_no_wr", 128'(wr_addr_q.size()), 128'(0));
    @(posedge clk); #1;
    check("clean_busy_fall", 128'(busy), 128'(0));
    check("clean_fv_pulse", 128'(fill_valid), 128'(0));
    @(posedge clk); #1;
    check("clean_entry_hold", 128'(fill_entry), 128'(e));

    // Dirty victim tag 3 idx 2 -> writes 0xD0/0xD4; request tag 5 idx 2 -> reads 0x150/0x154
    clear_logs();
    rd_data[0] = 32'h5555_0000;
    rd_data[1] = 32'h5555_0001;
    run_miss("dirty", 32'h0000_0150, mk(1'b1, 1'b1, 26'h3, 32'h11, 32'h22), 5, -1);
    check_pair("dirty_wr_addr", wr_addr_q, 32'hD0, 32'hD4);
    check_pair("dirty_wr_data", wr_data_q, 32'h11, 32'h22);
    check_pair("dirty_rd", rd_addr_q, 32'h150, 32'h154);
    check("dirty_entry", 128'(fill_entry), 128'(mk(1'b1, 1'b0, 26'h5, 32'h5555_0000, 32'h5555_0001)));
    @(posedge clk); #1;

    // Three BUSY cycles before every ACCESS
    clear_logs();
    lat_cfg = 3;
    rd_data[0] = 32'hC0C0_0001;
    rd_data[1] = 32'hC0C0_0002;
    run_miss("wait", 32'h0000_1A48, mk(1'b0, 1'b0, 26'h0, 32'h0, 32'h0), 9, -1);
    check("wait_entry", 128'(fill_entry), 128'(mk(1'b1, 1'b0, 26'h69, 32'hC0C0_0001, 32'hC0C0_0002)));
    check_pair("wait_rd", rd_addr_q, 32'h1A48, 32'h1A4C);
    lat_cfg = 0;
    @(posedge clk); #1;

    // ERROR on the second fill word, retried at the same address
    clear_logs();
    err_addr = 32'h1A4C;
    err_arm  = 1'b1;
    rd_data[0] = 32'hD0D0_0001;
    rd_data[1] = 32'hD0D0_0002;
    run_miss("error", 32'h0000_1A48, mk(1'b1, 1'b0, 26'h1, 32'h0, 32'h0), 4, -1);
    check("error_entry", 128'(fill_entry), 128'(mk(1'b1, 1'b0, 26'h69, 32'hD0D0_0001, 32'hD0D0_0002)));
    check_pair("error_rd", rd_addr_q, 32'h1A48, 32'h1A4C);
    @(posedge clk); #1;

    // miss_req pulsed during FILL must be ignored
    clear_logs();
    fv_before = fv_count;
    rd_data[0] = 32'h0F0F_0001;
    rd_data[1] = 32'h0F0F_0002;
    run_miss("pulse", 32'h0000_1A48, mk(1'b1, 1'b0, 26'h2, 32'h0, 32'h0), 3, 1);
    repeat (4) @(posedge clk);
    #1;
    check("pulse_one_fill", 128'(fv_count - fv_before), 128'(1));
    check("pulse_idle", 128'(busy), 128'(0));

    // Reset during the second writeback word
    clear_logs();
    fv_before = fv_count;
    miss_addr = dcachef_t'(32'h0000_0150);
    victim    = mk(1'b1, 1'b1, 26'h3, 32'h11, 32'h22);
    miss_req  = 1'b1;
    @(posedge clk); #1;
    miss_req = 1'b0;
    @(posedge clk); #1;
    check("rstmid_wb1_addr", 128'(ram_addr), 128'(32'hD4));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_busy", 128'(busy), 128'(0));
    check("rstmid_wen", 128'(ram_wen), 128'(0));
    check("rstmid_ren", 128'(ram_ren), 128'(0));
    check("rstmid_addr", 128'(ram_addr), 128'(0));
    check("rstmid_store", 128'(ram_store), 128'(0));
    check("rstmid_entry", 128'(fill_entry), 128'(0));
    repeat (8) @(posedge clk);
    #1;
    check("rstmid_no_fill", 128'(fv_count - fv_before), 128'(0));

    // Invalid but dirty victim: no writeback
    clear_logs();
    rd_data[0] = 32'h1234_0001;
    rd_data[1] = 32'h1234_0002;
    run_miss("inval", 32'h0000_0150, mk(1'b0, 1'b1, 26'h3, 32'h11, 32'h22), 3, -1);
    check("inval_no_wr", 128'(wr_addr_q.size()), 128'(0));
    check("inval_entry", 128'(fill_entry), 128'(mk(1'b1, 1'b0, 26'h5, 32'h1234_0001, 32'h1234_0002)));
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
